// File: rtl/rv32_mem_pkg.sv
// Shared constants for the RV32I data-memory path: funct3 width codes,
// load/store unit state encoding and default data_memory address width.
package rv32_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } lsu_state_t;

  // Misaligned, out-of-range, undefined width code or unsigned-width store.
  function automatic logic lsu_fault(input logic        store,
                                     input logic [2:0]  funct3,
                                     input logic [31:0] addr,
                                     input int unsigned addr_w);
    logic f;
    f = 1'b0;
    case (funct3)
      F3_B, F3_BU: f = 1'b0;
      F3_H, F3_HU: f = addr[0];
      F3_W:        f = |addr[1:0];
      default:     f = 1'b1;
    endcase
    if ((addr >> (addr_w + 2)) != '0) f = 1'b1;
    if (store && funct3[2]) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane extraction with sign/zero extension for loads, and
// lane merging of store data into a fetched word for sub-word stores.
module lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_word[{byte_off, 3'b000} +: 8];
    lane_h = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'h000000, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'h0000, lane_h};
      default: load_data = mem_word;
    endcase

    merged_word = mem_word;
    case (funct3[1:0])
      2'b00:   merged_word[{byte_off, 3'b000} +: 8]     = store_data[7:0];
      2'b01:   merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time against a data_memory whose
// read data is registered one edge after mem_read; SB/SH use read-modify-write.
module load_store_unit
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_t state, state_nx;

  logic [ADDR_W+1:0] addr_r;
  logic [2:0]        f3_r;
  logic              store_r;
  logic              fault_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;

  logic              accept;
  logic              req_fault;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign req_fault = lsu_fault(req_store, req_funct3, req_addr, ADDR_W);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)                           state_nx = ST_RESP;
          else if (req_store && req_funct3 == F3_W) state_nx = ST_WR;
          else                                     state_nx = ST_RD;
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        state_nx = ST_CAP;
      end
      ST_CAP:  state_nx = store_r ? ST_WR : ST_RESP;
      ST_WR: begin
        mem_write = 1'b1;
        state_nx  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // wdata_r doubles as the merged RMW word once CAP has sampled memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= '0;
      f3_r    <= '0;
      store_r <= 1'b0;
      fault_r <= 1'b0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else if (accept) begin
      addr_r  <= req_addr[ADDR_W+1:0];
      f3_r    <= req_funct3;
      store_r <= req_store;
      fault_r <= req_fault;
      wdata_r <= req_wdata;
      rdata_r <= '0;
    end else if (state == ST_CAP) begin
      if (store_r) wdata_r <= merged_word;
      else         rdata_r <= load_data;
    end
  end

  lsu_align u_align (
    .funct3      (f3_r),
    .byte_off    (addr_r[1:0]),
    .mem_word    (mem_read_data),
    .store_data  (wdata_r),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign mem_address    = (state == ST_RD || state == ST_CAP || state == ST_WR)
                          ? addr_r[ADDR_W+1:2] : '0;
  assign mem_write_data = (state == ST_WR) ? wdata_r : '0;
  assign resp_rdata     = (state == ST_RESP) ? rdata_r : '0;
  assign resp_fault     = (state == ST_RESP) ? fault_r : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, hand sequences for back-pressure
// and reset-in-WR, and random traffic against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // data_memory: synchronous write, read data registered one edge after mem_read
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    if (mem_read)  mem_read_data    <= mem[mem_address];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: byte-addressed semantics with plain arithmetic on ref_mem.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic flt, output logic [31:0] rd,
                                output int lat, output int nrd, output int nwr);
    int          size, w, off;
    longint      v;
    logic [31:0] word;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    flt  = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (st && f3[2]) ||
           (a % size != 0) || (a >= 32'd4096);
    rd = '0; lat = 1; nrd = 0; nwr = 0;
    if (flt) return;
    w    = int'(a / 4);
    off  = int'(a % 4);
    word = ref_mem[w];
    if (!st) begin
      v = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * size));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v -= (longint'(1) << (8 * size));
      rd  = v[31:0];
      lat = 3;
      nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) word[8 * (off + i) +: 8] = wd[8 * i +: 8];
      ref_mem[w] = word;
      lat = (size == 4) ? 2 : 4;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endfunction

  // One full transaction from IDLE back to IDLE; starts and ends at posedge+1.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, output logic flt,
                     output logic [31:0] rd, output int lat, output int nrd, output int nwr);
    int both;
    both = 0; nrd = 0; nwr = 0;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_store  = $urandom_range(0, 1);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (mem_read && mem_write) both++;
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    nrd += int'(mem_read);
    nwr += int'(mem_write);
    flt = resp_fault;
    rd  = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_fault", {31'b0, resp_fault}, {31'b0, flt});
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_released", {31'b0, resp_valid}, 32'd0);
    check("rd_wr_overlap", 32'(both), 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        flt;
    logic [31:0] rd;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [12];

  logic        o_flt, e_flt;
  logic [31:0] o_rd, e_rd;
  int          o_lat, o_nrd, o_nwr, e_lat, e_nrd, e_nwr;
  int          seen, diffs;
  logic [31:0] ra;

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 32'h2B, 32'h0,    1'b0, 32'hFFFFFFDE, 3, 1, 0, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 3'b100, 32'h2B, 32'h0,    1'b0, 32'h000000DE, 3, 1, 0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 3'b001, 32'h28, 32'h0,    1'b0, 32'hFFFFBEEF, 3, 1, 0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 3'b101, 32'h2A, 32'h0,    1'b0, 32'h0000DEAD, 3, 1, 0, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 3'b000, 32'h29, 32'h12,   1'b0, 32'h0,        4, 1, 1, 32'hDEAD12EF};
    tbl[5]  = '{1'b1, 3'b001, 32'h2A, 32'hCAFE, 1'b0, 32'h0,        4, 1, 1, 32'hCAFE12EF};
    tbl[6]  = '{1'b0, 3'b010, 32'h28, 32'h0,    1'b0, 32'hCAFE12EF, 3, 1, 0, 32'hCAFE12EF};
    tbl[7]  = '{1'b0, 3'b010, 32'h2A, 32'h0,    1'b1, 32'h0,        1, 0, 0, 32'hCAFE12EF};
    tbl[8]  = '{1'b1, 3'b001, 32'h29, 32'hFFFF, 1'b1, 32'h0,        1, 0, 0, 32'hCAFE12EF};
    tbl[9]  = '{1'b0, 3'b010, 32'h1000, 32'h0,  1'b1, 32'h0,        1, 0, 0, 32'h0BADF00D};
    tbl[10] = '{1'b0, 3'b011, 32'h28, 32'h0,    1'b1, 32'h0,        1, 0, 0, 32'hCAFE12EF};
    tbl[11] = '{1'b1, 3'b100, 32'h28, 32'h55,   1'b1, 32'h0,        1, 0, 0, 32'hCAFE12EF};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]  = 32'h0BADF00D;
    mem[10] = 32'hDEADBEEF;
    mem[12] = 32'h11223344;
    mem_read_data = '0;

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #12;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_address", {22'b0, mem_address}, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, 0, o_flt, o_rd, o_lat, o_nrd, o_nwr);
      check($sformatf("vec%0d_fault", i), {31'b0, o_flt}, {31'b0, tbl[i].flt});
      check($sformatf("vec%0d_rdata", i), o_rd, tbl[i].rd);
      check($sformatf("vec%0d_latency", i), 32'(o_lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d_mem_read", i), 32'(o_nrd), 32'(tbl[i].nrd));
      check($sformatf("vec%0d_mem_write", i), 32'(o_nwr), 32'(tbl[i].nwr));
      check($sformatf("vec%0d_word", i), mem[tbl[i].a[11:2]], tbl[i].word);
    end

    // SW under back-pressure, then read it back
    txn(1'b1, 3'b010, 32'h14, 32'h12345678, 3, o_flt, o_rd, o_lat, o_nrd, o_nwr);
    check("sw_bp_fault", {31'b0, o_flt}, 32'd0);
    check("sw_bp_rdata", o_rd, 32'd0);
    check("sw_bp_latency", 32'(o_lat), 32'd2);
    check("sw_bp_mem_write", 32'(o_nwr), 32'd1);
    check("sw_bp_mem_read", 32'(o_nrd), 32'd0);
    check("sw_bp_word", mem[5], 32'h12345678);
    txn(1'b0, 3'b010, 32'h14, 32'h0, 0, o_flt, o_rd, o_lat, o_nrd, o_nwr);
    check("lw_back_rdata", o_rd, 32'h12345678);
    check("lw_back_latency", 32'(o_lat), 32'd3);

    // Reset asserted during the WR cycle of an SB
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8 && !mem_write; c++) begin
      @(posedge clk); #1;
    end
    seen = int'(mem_write);
    check("sb_reached_wr", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_wr_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_wr_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_wr_mem_address", {22'b0, mem_address}, 32'd0);
    check("rst_wr_mem_wdata", mem_write_data, 32'd0);
    @(posedge clk); #1;
    check("rst_wr_word_kept", mem[12], 32'h11223344);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_wr_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wr_no_resp", {31'b0, resp_valid}, 32'd0);
    check("rst_wr_word_after", mem[12], 32'h11223344);

    // Random traffic against the reference model
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255));
      req_store = $urandom_range(0, 1);
      req_funct3 = 3'($urandom);
      req_wdata = $urandom;
      model(req_store, req_funct3, ra, req_wdata, e_flt, e_rd, e_lat, e_nrd, e_nwr);
      txn(req_store, req_funct3, ra, req_wdata, $urandom_range(0, 2), o_flt, o_rd, o_lat, o_nrd, o_nwr);
      check("rnd_fault", {31'b0, o_flt}, {31'b0, e_flt});
      check("rnd_rdata", o_rd, e_rd);
      check("rnd_latency", 32'(o_lat), 32'(e_lat));
      check("rnd_mem_read", 32'(o_nrd), 32'(e_nrd));
      check("rnd_mem_write", 32'(o_nwr), 32'(e_nwr));
    end
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("rnd_memory_image", 32'(diffs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the data_memory word-address width (1024 words, 4 KiB).
REQ-002 SHALL have port clk  input  1  rising-edge clock shared with data_memory.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  core presents an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts the access (high only in IDLE).
REQ-006 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address from the ALU.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_ready  input  1  core consumes the result.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-013 SHALL have port resp_fault  output  1  misaligned, out-of-range or illegal access.
REQ-014 SHALL have ports mem_read and mem_write  output  1 each, plus mem_address  output  ADDR_W, driving data_memory.
REQ-015 SHALL have ports mem_write_data  output  32  and  mem_read_data  input  32, connected to data_memory.

Function
REQ-016 SHALL implement the states IDLE, RD, CAP, WR and RESP.
REQ-017 SHALL accept a request on the edge where req_valid and req_ready are both high, latching the address, funct3, store flag and write data.
REQ-018 SHALL fault when any of these holds: H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:ADDR_W+2]!=0; funct3 in {011,110,111}; a store with funct3[2]=1.
REQ-019 SHALL go from IDLE to RESP on a faulting request, raising resp_fault and asserting neither mem_read nor mem_write.
REQ-020 SHALL drive mem_address with addr[ADDR_W+1:2] throughout RD, CAP and WR.
REQ-021 SHALL follow IDLE -> RD -> CAP -> RESP for a load, asserting mem_read only in RD and sampling mem_read_data in CAP, since data_memory registers its read data one edge after mem_read.
REQ-022 SHALL follow IDLE -> WR -> RESP for SW, asserting mem_write for exactly one cycle with mem_write_data = wdata.
REQ-023 SHALL follow IDLE -> RD -> CAP -> WR -> RESP for SB and SH (read-modify-write).
REQ-024 SHALL, in CAP, merge the store data into byte lane addr[1:0] for SB, or halfword lane addr[1] for SH, leaving the other lanes unchanged.
REQ-025 SHALL sign-extend B/H loads and zero-extend BU/HU loads, selecting the byte by addr[1:0] and the halfword by addr[1].
REQ-026 SHALL hold resp_valid, resp_rdata and resp_fault stable in RESP until resp_ready is high, then return to IDLE.
REQ-027 SHALL meet these latencies from the accept edge to resp_valid: load 3 cycles, SW 2, SB/SH 4, fault 1.
REQ-028 SHALL have a minimum of one IDLE cycle between responses; there is no request pipelining.
REQ-029 SHALL never assert mem_read and mem_write in the same cycle.

Reset
REQ-030 SHALL, while rst_n is low, force state IDLE and drive resp_valid=0, resp_fault=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0 and mem_write_data=0.
REQ-031 SHALL have req_ready=1 in the first cycle after rst_n deasserts.
REQ-032 SHALL, on a reset mid-operation (including in WR), drop mem_write immediately (asynchronously), issue no partial write afterward, and discard the pending response.

Structure
REQ-033 SHALL take the funct3 constants, state encodings and ADDR_W default from the shared package rv32_mem_pkg.
REQ-034 SHALL place lane extraction, extension and store merging in one combinational sub-module, lsu_align; the state machine and registers stay in load_store_unit.

Verification
REQ-035 SHALL cover: word 10 preloaded 0xDEADBEEF; LB at 0x2B -> 0xFFFFFFDE; LBU at 0x2B -> 0x000000DE; LH at 0x28 -> 0xFFFFBEEF; LHU at 0x2A -> 0x0000DEAD; each takes 3 cycles.
REQ-036 SHALL cover: SB of 0x12 at 0x29 over 0xDEADBEEF -> word 10 = 0xDEAD12EF; SH of 0xCAFE at 0x2A -> 0xCAFE12EF; exactly one mem_write pulse each.
REQ-037 SHALL cover: LW at 0x2A, SH at 0x29, LW at 0x1000 and funct3=011 -> resp_fault=1 after 1 cycle, resp_rdata=0, no mem_read/mem_write pulse.
REQ-038 SHALL cover: SW of 0x12345678 at 0x14 with resp_ready held low for 3 cycles -> resp held stable, req_ready=0 throughout, then LW at 0x14 -> 0x12345678.
REQ-039 SHALL cover: rst_n pulled low in the WR cycle of an SB -> mem_write drops in the same cycle, the word is unchanged, and req_ready=1 after release.
